// File: rtl/mem_read_arbiter.sv
// Shares one main-memory read bus between the I-cache (port I) and the D-cache (port D).
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default is fixed priority, D over I.
module mem_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 128
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    output logic              i_rrdy,
    input  logic [3:0]        i_ren,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_abort,
    output logic              i_rvalid,
    output logic [BLK_W-1:0]  i_rdata,
    output logic              d_rrdy,
    input  logic [3:0]        d_ren,
    input  logic [ADDR_W-1:0] d_raddr,
    output logic              d_rvalid,
    output logic [BLK_W-1:0]  d_rdata,
    input  logic              mem_rrdy,
    output logic [3:0]        mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic              mem_rvalid,
    input  logic [BLK_W-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              pend_i_q, pend_i_d;
    logic              pend_d_q, pend_d_d;
    logic [3:0]        i_ren_q, i_ren_d;
    logic [3:0]        d_ren_q, d_ren_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [3:0]        mem_ren_q, mem_ren_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic              i_drop_q, i_drop_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    logic busy_i, busy_d, resp, pend_i_eff, grant, issue, issue_sel;

    assign busy_i = (state_q != IDLE) && (owner_q == OWN_I);
    assign busy_d = (state_q != IDLE) && (owner_q == OWN_D);
    assign i_rrdy = ~pend_i_q & ~busy_i;
    assign d_rrdy = ~pend_d_q & ~busy_d;

    // An aborted I transaction still completes on the bus; only its response is hidden.
    assign resp     = (state_q == WAIT) && mem_rvalid;
    assign i_rvalid = resp && (owner_q == OWN_I) && !i_drop_q && !i_abort;
    assign d_rvalid = resp && (owner_q == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    assign mem_ren   = mem_ren_q;
    assign mem_raddr = mem_raddr_q;

    assign pend_i_eff = pend_i_q & ~i_abort;
`ifdef ARB_ROUND_ROBIN_EN
    assign grant = (pend_i_eff && pend_d_q) ? ~last_q : pend_d_q;
`else
    assign grant = pend_d_q ? OWN_D : OWN_I;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pend_i_d    = pend_i_q;
        pend_d_d    = pend_d_q;
        i_ren_d     = i_ren_q;
        d_ren_d     = d_ren_q;
        i_addr_d    = i_addr_q;
        d_addr_d    = d_addr_q;
        i_drop_d    = i_drop_q;
        mem_ren_d   = '0;
        mem_raddr_d = '0;
        issue       = 1'b0;
        issue_sel   = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif

        if (i_abort) pend_i_d = 1'b0;
        if ((i_ren != 4'd0) && i_rrdy && !i_abort) begin
            pend_i_d = 1'b1;
            i_ren_d  = i_ren;
            i_addr_d = i_raddr;
        end
        if ((d_ren != 4'd0) && d_rrdy) begin
            pend_d_d = 1'b1;
            d_ren_d  = d_ren;
            d_addr_d = d_raddr;
        end

        case (state_q)
            IDLE: begin
                if (pend_i_eff || pend_d_q) begin
                    owner_d = grant;
                    if (mem_rrdy) begin
                        issue     = 1'b1;
                        issue_sel = grant;
                        state_d   = WAIT;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if ((owner_q == OWN_I) && i_abort) begin
                    state_d = IDLE;
                end else if (mem_rrdy) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if ((owner_q == OWN_I) && i_abort) i_drop_d = 1'b1;
                if (mem_rvalid) begin
                    state_d  = IDLE;
                    i_drop_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            if (issue_sel == OWN_D) begin
                mem_ren_d   = d_ren_q;
                mem_raddr_d = d_addr_q;
                pend_d_d    = 1'b0;
            end else begin
                mem_ren_d   = i_ren_q;
                mem_raddr_d = i_addr_q;
                pend_i_d    = 1'b0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_d = issue_sel;
`endif
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            pend_i_q    <= 1'b0;
            pend_d_q    <= 1'b0;
            i_ren_q     <= '0;
            d_ren_q     <= '0;
            i_addr_q    <= '0;
            d_addr_q    <= '0;
            i_drop_q    <= 1'b0;
            mem_ren_q   <= '0;
            mem_raddr_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= OWN_D;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            pend_i_q    <= pend_i_d;
            pend_d_q    <= pend_d_d;
            i_ren_q     <= i_ren_d;
            d_ren_q     <= d_ren_d;
            i_addr_q    <= i_addr_d;
            d_addr_q    <= d_addr_d;
            i_drop_q    <= i_drop_d;
            mem_ren_q   <= mem_ren_d;
            mem_raddr_q <= mem_raddr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: expected memory requests and port responses are queued
// as stimulus is driven and popped as the DUT produces them.
module tb_mem_read_arbiter;

    logic         cpu_clk = 1'b0;
    logic         cpu_rstn;
    logic         i_rrdy, i_rvalid, d_rrdy, d_rvalid;
    logic [3:0]   i_ren, d_ren, mem_ren;
    logic [31:0]  i_raddr, d_raddr, mem_raddr;
    logic         i_abort, mem_rrdy, mem_rvalid;
    logic [127:0] i_rdata, d_rdata, mem_rdata;

    typedef struct {
        logic [3:0]  ren;
        logic [31:0] addr;
    } req_t;
    typedef struct {
        logic         port;
        logic [127:0] data;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;

    mem_read_arbiter #(.ADDR_W(32), .BLK_W(128)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
        .i_rrdy(i_rrdy), .i_ren(i_ren), .i_raddr(i_raddr), .i_abort(i_abort),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_rrdy(d_rrdy), .d_ren(d_ren), .d_raddr(d_raddr),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_rrdy(mem_rrdy), .mem_ren(mem_ren), .mem_raddr(mem_raddr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [3:0] ren, input logic [31:0] addr);
        req_t r;
        r.ren = ren;
        r.addr = addr;
        req_q.push_back(r);
    endtask

    task automatic push_resp(input logic port, input logic [127:0] data);
        resp_t r;
        r.port = port;
        r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic monitor();
        req_t  rq;
        resp_t rs;
        if (mem_ren !== 4'd0) begin
            chk("req_expected", 128'(req_q.size() > 0), 128'd1);
            if (req_q.size() > 0) begin
                rq = req_q.pop_front();
                chk("req_ren", 128'(mem_ren), 128'(rq.ren));
                chk("req_addr", 128'(mem_raddr), 128'(rq.addr));
            end
        end
        if (i_rvalid || d_rvalid) begin
            chk("resp_expected", 128'(resp_q.size() > 0), 128'd1);
            chk("resp_onehot", 128'(i_rvalid && d_rvalid), 128'd0);
            if (resp_q.size() > 0) begin
                rs = resp_q.pop_front();
                chk("resp_port", 128'(d_rvalid), 128'(rs.port));
                chk("resp_data", d_rvalid ? d_rdata : i_rdata, rs.data);
            end
        end
    endtask

    // Each call covers one clock cycle: inputs already applied, outputs sampled mid-low-phase.
    task automatic tick();
        #1;
        monitor();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic clear_inputs();
        i_ren = '0; i_raddr = '0; i_abort = 1'b0;
        d_ren = '0; d_raddr = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        logic [31:0] first_addr, second_addr;
        logic        first_port;

        cpu_rstn = 1'b0;
        clear_inputs();
        mem_rrdy = 1'b1;
        repeat (2) @(negedge cpu_clk);
        chk("rst_mem_ren", 128'(mem_ren), 128'd0);
        chk("rst_mem_raddr", 128'(mem_raddr), 128'd0);
        chk("rst_i_rvalid", 128'(i_rvalid), 128'd0);
        chk("rst_d_rvalid", 128'(d_rvalid), 128'd0);
        chk("rst_i_rdata", i_rdata, 128'd0);
        chk("rst_i_rrdy", 128'(i_rrdy), 128'd1);
        chk("rst_d_rrdy", 128'(d_rrdy), 128'd1);
        cpu_rstn = 1'b1;
        @(negedge cpu_clk);

        // Simultaneous I/D pulses: first tie after reset
`ifdef ARB_ROUND_ROBIN_EN
        first_port = 1'b0; first_addr = 32'h100; second_addr = 32'h200;
        push_req(4'h3, 32'h100); push_req(4'hC, 32'h200);
`else
        first_port = 1'b1; first_addr = 32'h200; second_addr = 32'h100;
        push_req(4'hC, 32'h200); push_req(4'h3, 32'h100);
`endif
        i_ren = 4'h3; i_raddr = 32'h100; d_ren = 4'hC; d_raddr = 32'h200;
        tick();
        clear_inputs();
        tick();
        #1 chk("tie_first_addr", 128'(mem_raddr), 128'(first_addr));
        tick();
        mem_rvalid = 1'b1; mem_rdata = {8{16'h1111}}; push_resp(first_port, {8{16'h1111}});
        tick();
        clear_inputs();
        tick();
        #1 chk("tie_second_addr", 128'(mem_raddr), 128'(second_addr));
        tick();
        mem_rvalid = 1'b1; mem_rdata = {8{16'h2222}}; push_resp(~first_port, {8{16'h2222}});
        tick();
        clear_inputs();

        // Single I request, latency and response routing
        i_ren = 4'hF; i_raddr = 32'h0000_1230; push_req(4'hF, 32'h0000_1230);
        tick();
        clear_inputs();
        #1 chk("s1_i_rrdy_pend", 128'(i_rrdy), 128'd0);
        chk("s1_mem_ren_c1", 128'(mem_ren), 128'd0);
        tick();
        #1 chk("s1_mem_ren_c2", 128'(mem_ren), 128'hF);
        chk("s1_mem_raddr_c2", 128'(mem_raddr), 128'h1230);
        tick();
        #1 chk("s1_mem_ren_c3", 128'(mem_ren), 128'd0);
        chk("s1_mem_raddr_c3", 128'(mem_raddr), 128'd0);
        mem_rvalid = 1'b1; mem_rdata = {16{8'hA5}}; push_resp(1'b0, {16{8'hA5}});
        #1 chk("s1_i_rvalid", 128'(i_rvalid), 128'd1);
        chk("s1_i_rdata", i_rdata, {16{8'hA5}});
        chk("s1_d_rvalid", 128'(d_rvalid), 128'd0);
        chk("s1_d_rdata", d_rdata, 128'd0);
        chk("s1_i_rrdy_resp", 128'(i_rrdy), 128'd0);
        tick();
        clear_inputs();
        #1 chk("s1_i_rrdy_after", 128'(i_rrdy), 128'd1);

        // mem_rrdy low: I held, D captured meanwhile, I still issued first
        mem_rrdy = 1'b0;
        i_ren = 4'h1; i_raddr = 32'h300; push_req(4'h1, 32'h300);
        tick();
        clear_inputs();
        tick();
        d_ren = 4'h2; d_raddr = 32'h400; push_req(4'h2, 32'h400);
        tick();
        clear_inputs();
        #1 chk("hold_d_rrdy", 128'(d_rrdy), 128'd0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold_mem_ren", 128'(mem_ren), 128'd0);
            tick();
        end
        mem_rrdy = 1'b1;
        tick();
        #1 chk("hold_i_first", 128'(mem_raddr), 128'h300);
        tick();
        mem_rvalid = 1'b1; mem_rdata = {8{16'h3333}}; push_resp(1'b0, {8{16'h3333}});
        tick();
        clear_inputs();
        tick();
        #1 chk("hold_d_second", 128'(mem_raddr), 128'h400);
        tick();
        mem_rvalid = 1'b1; mem_rdata = {8{16'h4444}}; push_resp(1'b1, {8{16'h4444}});
        tick();
        clear_inputs();

        // Abort in HOLD: nothing issued
        mem_rrdy = 1'b0;
        i_ren = 4'hF; i_raddr = 32'h500;
        tick();
        clear_inputs();
        tick();
        i_abort = 1'b1;
        tick();
        clear_inputs();
        #1 chk("abort_hold_i_rrdy", 128'(i_rrdy), 128'd1);
        mem_rrdy = 1'b1;
        repeat (3) tick();
        #1 chk("abort_hold_no_req", 128'(mem_ren), 128'd0);

        // Abort in WAIT: response swallowed, pending D issued next
        i_ren = 4'hF; i_raddr = 32'h600; push_req(4'hF, 32'h600);
        tick();
        clear_inputs();
        tick();
        d_ren = 4'h4; d_raddr = 32'h700; push_req(4'h4, 32'h700);
        i_abort = 1'b1;
        tick();
        clear_inputs();
        mem_rvalid = 1'b1; mem_rdata = {8{16'h6666}};
        #1 chk("abort_wait_i_rvalid", 128'(i_rvalid), 128'd0);
        chk("abort_wait_i_rdata", i_rdata, 128'd0);
        chk("abort_wait_d_rvalid", 128'(d_rvalid), 128'd0);
        tick();
        clear_inputs();
        tick();
        #1 chk("abort_wait_d_issued", 128'(mem_raddr), 128'h700);
        tick();
        mem_rvalid = 1'b1; mem_rdata = {8{16'h7777}}; push_resp(1'b1, {8{16'h7777}});
        tick();
        clear_inputs();

        // Request while not ready is dropped
        d_ren = 4'h1; d_raddr = 32'h800; push_req(4'h1, 32'h800);
        tick();
        d_ren = 4'h2; d_raddr = 32'h900;
        #1 chk("drop_d_rrdy", 128'(d_rrdy), 128'd0);
        tick();
        clear_inputs();
        repeat (2) tick();
        mem_rvalid = 1'b1; mem_rdata = {8{16'h8888}}; push_resp(1'b1, {8{16'h8888}});
        tick();
        clear_inputs();
        repeat (3) tick();
        #1 chk("drop_no_second_req", 128'(mem_ren), 128'd0);

        // Spurious mem_rvalid in IDLE
        mem_rvalid = 1'b1; mem_rdata = {8{16'hDEAD}};
        #1 chk("spur_i_rvalid", 128'(i_rvalid), 128'd0);
        chk("spur_d_rvalid", 128'(d_rvalid), 128'd0);
        tick();
        clear_inputs();

        // Abort coincident with i_ren: not captured
        i_ren = 4'hF; i_raddr = 32'hA00; i_abort = 1'b1;
        tick();
        clear_inputs();
        #1 chk("abort_same_i_rrdy", 128'(i_rrdy), 128'd1);
        repeat (2) tick();

        // Reset in WAIT, late response ignored, then normal service
        i_ren = 4'hF; i_raddr = 32'hB00; push_req(4'hF, 32'hB00);
        tick();
        clear_inputs();
        repeat (2) tick();
        cpu_rstn = 1'b0;
        #1 chk("rstw_mem_ren", 128'(mem_ren), 128'd0);
        chk("rstw_mem_raddr", 128'(mem_raddr), 128'd0);
        chk("rstw_i_rvalid", 128'(i_rvalid), 128'd0);
        tick();
        cpu_rstn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = {8{16'hBADB}};
        #1 chk("rstw_late_i_rvalid", 128'(i_rvalid), 128'd0);
        chk("rstw_late_d_rvalid", 128'(d_rvalid), 128'd0);
        tick();
        clear_inputs();
        i_ren = 4'h7; i_raddr = 32'hC00; push_req(4'h7, 32'hC00);
        tick();
        clear_inputs();
        tick();
        #1 chk("rstw_new_req", 128'(mem_raddr), 128'hC00);
        tick();
        mem_rvalid = 1'b1; mem_rdata = {8{16'hC0DE}}; push_resp(1'b0, {8{16'hC0DE}});
        #1 chk("rstw_new_i_rvalid", 128'(i_rvalid), 128'd1);
        tick();
        clear_inputs();
        tick();

        chk("req_queue_drained", 128'(req_q.size()), 128'd0);
        chk("resp_queue_drained", 128'(resp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
